mem_scheduler: RTL

- Single-port arbiter and sequencer for the shared pixel memory (ZBT, fixed read latency).
- Serves three requesters:
  - VGA read path: display refill.
  - NTSC capture write path.
  - Processor read/write port.
- Owns the double-buffer bank selection, swapping the display and capture banks at frame boundaries.
- Sits between the requesters and the memory pins wrapper.

---
 rtl/mem_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_scheduler.sv
// Single-port arbiter/sequencer for the shared ZBT pixel memory.
// Grants VGA, NTSC and processor requests, tracks read returns and owns the display/capture bank swap.
module mem_scheduler #(
    parameter int DW     = 36,
    parameter int AW     = 19,
    parameter int LAT    = 2,
    parameter int STARVE = 16
) (
    input  logic          clock,
    input  logic          reset_b,
    input  logic          frame_flag,

    input  logic          vga_req,
    input  logic [AW-2:0] vga_addr,
    output logic          vga_ack,
    output logic          vga_done,
    output logic [DW-1:0] vga_data,

    input  logic          ntsc_req,
    input  logic [AW-2:0] ntsc_addr,
    input  logic [DW-1:0] ntsc_wdata,
    output logic          ntsc_ack,
    input  logic          ntsc_frame_end,

    input  logic          proc_req,
    input  logic          proc_we,
    input  logic [AW-1:0] proc_addr,
    input  logic [DW-1:0] proc_wdata,
    output logic          proc_ack,
    output logic          proc_done,
    output logic [DW-1:0] proc_rdata,

    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          display_bank,
    output logic          capture_bank
);

    localparam int SW = $clog2(STARVE + 1);

    typedef enum logic [1:0] {
        TAG_NONE    = 2'd0,
        TAG_VGA     = 2'd1,
        TAG_PROC_RD = 2'd2,
        TAG_PROC_WR = 2'd3
    } tag_t;

    logic          run_q;
    logic [SW-1:0] starve_cnt;
    logic          starve_hit;
    logic          frame_ready;
    logic          capture_q;
    logic          swap;
    tag_t          tag_d;
    tag_t          tag_q [0:LAT];

    // Grants are held off until the first clock after reset release.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign starve_hit = proc_req && (starve_cnt == SW'(STARVE));

    always_comb begin
        vga_ack  = 1'b0;
        ntsc_ack = 1'b0;
        proc_ack = 1'b0;
        if (run_q) begin
            if (starve_hit) begin
                proc_ack = 1'b1;
            end else if (vga_req) begin
                vga_ack = 1'b1;
            end else if (ntsc_req) begin
                ntsc_ack = 1'b1;
            end else if (proc_req) begin
                proc_ack = 1'b1;
            end
        end
    end

    always_comb begin
        tag_d = TAG_NONE;
        if (vga_ack) begin
            tag_d = TAG_VGA;
        end else if (proc_ack) begin
            tag_d = proc_we ? TAG_PROC_WR : TAG_PROC_RD;
        end
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            starve_cnt <= '0;
        end else if (!proc_req || proc_ack) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SW'(STARVE)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Command issue; bank bits come from the grant cycle so a swap cannot redirect it.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (vga_ack) begin
                mem_addr <= {display_bank, vga_addr};
            end else if (ntsc_ack) begin
                mem_addr  <= {capture_bank, ntsc_addr};
                mem_wdata <= ntsc_wdata;
                mem_we    <= 1'b1;
            end else if (proc_ack) begin
                mem_addr  <= proc_addr;
                mem_wdata <= proc_wdata;
                mem_we    <= proc_we;
            end
        end
    end

    // tag_q[i] describes the command that was on the memory pins i cycles ago.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i <= LAT; i++) begin
                tag_q[i] <= TAG_NONE;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i <= LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            vga_done   <= 1'b0;
            vga_data   <= '0;
            proc_done  <= 1'b0;
            proc_rdata <= '0;
        end else begin
            vga_done  <= (tag_q[LAT] == TAG_VGA);
            proc_done <= (tag_q[LAT] == TAG_PROC_RD) || (tag_q[LAT] == TAG_PROC_WR);
            if (tag_q[LAT] == TAG_VGA) begin
                vga_data <= mem_rdata;
            end
            if (tag_q[LAT] == TAG_PROC_RD) begin
                proc_rdata <= mem_rdata;
            end
        end
    end

    // Display always shows the bank not being captured, so only one bank bit is stored.
    assign swap = frame_flag && (frame_ready || ntsc_frame_end);

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            capture_q   <= 1'b1;
            frame_ready <= 1'b0;
        end else if (swap) begin
            capture_q   <= ~capture_q;
            frame_ready <= 1'b0;
        end else if (ntsc_frame_end) begin
            frame_ready <= 1'b1;
        end
    end

    assign capture_bank = capture_q;
    assign display_bank = ~capture_q;

endmodule
